// File: rtl/mips_shift_pkg.sv
// Shared types and constants for the MIPS right-shift datapath.
// Holds the shift opcode encoding, the iterative shifter state enum and
// the default operand / shift-amount widths.
package mips_shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROTR = 2'b10,
    OP_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-step right shifter: shifts value right by k bits
// (0..STEP) according to op. SRA ORs in the supplied fill bit at the top,
// ROTR (only when SHIFT_RIGHT_ROTATE_EN is defined) wraps the low bits to
// the top, every other opcode behaves as SRL.
// Ports:
//   value  - operand for this step
//   k      - bits to shift this step, 0..STEP
//   op     - shift opcode
//   fill   - sign bit used for SRA fill
//   result - shifted value
module shift_right_step
  import mips_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned STEP  = 1,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  shift_op_t        op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // One mux leg per legal step size; k==0 passes value through.
  always_comb begin
    result = value;
    for (int i = 1; i <= int'(STEP); i++) begin
      if (k == KW'(i)) begin
        result = value >> i;
        if (op == OP_SRA && fill) begin
          result = result | ~({WIDTH{1'b1}} >> i);
        end
`ifdef SHIFT_RIGHT_ROTATE_EN
        if (op == OP_ROTR) begin
          result = result | (value << (WIDTH - i));
        end
`endif
      end
    end
  end

endmodule

// File: rtl/shift_right_unit.sv
// Iterative multi-cycle right shifter (SRL / SRA, optional ROTR) with a
// valid/ready handshake on both sides. Shifts up to STEP bits per clock.
// Optional feature macro: SHIFT_RIGHT_ROTATE_EN (enables in_op=10 rotate;
// otherwise in_op=10 executes as SRL). in_op=11 always executes as SRL.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid / in_ready   - request handshake
//   in_data, in_shamt     - operand and shift amount (sampled at accept)
//   in_op                 - 00 SRL, 01 SRA, 10 ROTR, 11 reserved
//   out_valid / out_ready - result handshake
//   out_data              - result, held stable until consumed
module shift_right_unit #(
  parameter int unsigned WIDTH   = mips_shift_pkg::DATA_W,
  parameter int unsigned SHAMT_W = mips_shift_pkg::SHAMT_W,
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);
  import mips_shift_pkg::*;

  localparam int unsigned KW = $clog2(STEP + 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] rem_q;
  shift_op_t          op_q;
  logic               fill_q;

  logic [KW-1:0]      k_c;
  logic               last_c;
  logic               accept_c;
  logic [WIDTH-1:0]   step_c;

  // Step size this cycle: min(STEP, remaining).
  always_comb begin
    k_c      = (rem_q < SHAMT_W'(STEP)) ? KW'(rem_q) : KW'(STEP);
    last_c   = (rem_q == SHAMT_W'(k_c));
    accept_c = (state_q == IDLE) && in_valid;
  end

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value  (data_q),
    .k      (k_c),
    .op     (op_q),
    .fill   (fill_q),
    .result (step_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath, counter and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      op_q      <= OP_SRL;
      fill_q    <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (accept_c) begin
        data_q <= in_data;
        rem_q  <= in_shamt;
        op_q   <= shift_op_t'(in_op);
        fill_q <= in_data[WIDTH-1];
        if (in_shamt == '0) begin
          out_data <= in_data;
        end
      end else if (state_q == SHIFT) begin
        data_q <= step_c;
        rem_q  <= rem_q - SHAMT_W'(k_c);
        if (last_c) begin
          out_data <= step_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_right_unit.sv
// Self-checking bench for shift_right_unit: one STEP=1 and one STEP=4
// instance, a shared request bus steered by sel, and a scoreboard of
// expected results and latencies.
module tb_shift_right_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic        cur_in_ready, cur_out_valid;
  logic [31:0] cur_out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & ~sel), .in_ready(in_ready0),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid0), .out_ready(out_ready | sel), .out_data(out_data0)
  );

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & sel), .in_ready(in_ready1),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid1), .out_ready(out_ready | ~sel), .out_data(out_data1)
  );

  assign cur_in_ready  = sel ? in_ready1  : in_ready0;
  assign cur_out_valid = sel ? out_valid1 : out_valid0;
  assign cur_out_data  = sel ? out_data1  : out_data0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b01: r = 32'($signed(d) >>> s);
`ifdef SHIFT_RIGHT_ROTATE_EN
      2'b10: r = (d >> s) | ((s == 0) ? 32'h0 : (d << (32 - s)));
`endif
      default: r = d >> s;
    endcase
    return r;
  endfunction

  // Issue one request on instance s, wait for its result, optionally
  // stall the consumer for hold cycles, then hand it off.
  task automatic run_op(input logic s, input logic [31:0] d, input int sh,
                        input logic [1:0] op, input int hold);
    int lat;
    int step;
    logic [31:0] held;
    step = s ? 4 : 1;
    exp_q.push_back(model(d, sh, op));
    lat_q.push_back((sh == 0) ? 1 : (sh + step - 1) / step + 1);
    sel = s;
    check("in_ready_idle", 32'(cur_in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = 5'(sh);
    in_op     = op;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (cur_out_valid || lat > 100) break;
      check("in_ready_busy", 32'(cur_in_ready), 32'd0);
    end
    check("out_valid_seen", 32'(cur_out_valid), 32'd1);
    check("latency", 32'(lat), 32'(lat_q.pop_front()));
    check("out_data", cur_out_data, exp_q.pop_front());
    check("in_ready_done", 32'(cur_in_ready), 32'd0);
    held = cur_out_data;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(cur_out_valid), 32'd1);
      check("hold_data", cur_out_data, held);
      check("hold_in_ready", 32'(cur_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(cur_out_valid), 32'd0);
    check("post_in_ready", 32'(cur_in_ready), 32'd1);
    check("post_data_held", cur_out_data, held);
  endtask

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready0", 32'(in_ready0), 32'd1);
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_out_data0", out_data0, 32'h0);
    check("rst_in_ready1", 32'(in_ready1), 32'd1);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_out_data1", out_data1, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(1'b0, 32'h8000_0000, 4,  2'b00, 0);
    run_op(1'b0, 32'hFFFF_FFF0, 2,  2'b01, 0);
    run_op(1'b0, 32'h7FFF_FFFF, 31, 2'b01, 0);
    run_op(1'b0, 32'h1234_5678, 0,  2'b01, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 31, 2'b00, 0);
    run_op(1'b1, 32'h8000_0000, 31, 2'b01, 0);
    run_op(1'b1, 32'hF000_0000, 5,  2'b01, 0);
    run_op(1'b1, 32'hABCD_0000, 4,  2'b11, 0);
    run_op(1'b1, 32'h0000_00F0, 3,  2'b00, 0);
    run_op(1'b0, 32'hDEAD_BEEF, 7,  2'b01, 6);
    run_op(1'b1, 32'hDEAD_BEEF, 9,  2'b01, 6);
    run_op(1'b0, 32'h0000_0001, 1,  2'b10, 0);
    run_op(1'b1, 32'h8765_4321, 13, 2'b10, 2);

    // Reset during SHIFT discards the operation.
    sel = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_0000; in_shamt = 5'd20; in_op = 2'b00;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid0), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready0), 32'd1);
    check("mid_rst_out_data", out_data0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_out_valid", 32'(out_valid0), 32'd0);
    run_op(1'b0, 32'h0000_0100, 8, 2'b00, 0);

    // Random mix over both instances.
    for (int n = 0; n < 24; n++) begin
      run_op(1'(n & 1), $urandom, int'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
Name: shift_right_unit

Overview:
- Iterative multi-cycle right shifter for the MIPS datapath; the right-shift counterpart of the fixed shift-left-by-2 block.
- Executes SRL/SRA (and optionally ROTR) on a 32-bit operand, shifting STEP bits per clock until the shift amount is consumed.
- Uses a valid/ready handshake on both sides, so the ALU/control path can issue an operation and stall until the result is back.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 1, maximum bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  2  00 SRL, 01 SRA, 10 ROTR, 11 reserved (executes as SRL)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, internal counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch data, shamt and op.
    - shamt==0: go to DONE.
    - otherwise: go to SHIFT with remaining=shamt.
  - SHIFT: in_ready=0. Each cycle, shift by k=min(STEP, remaining) and set remaining -= k. When remaining reaches 0 after the update, go to DONE.
  - DONE: out_valid=1 and out_data holds the result. On out_ready, go to IDLE.
- No bypass: in_ready=0 in DONE, so a new request cannot be taken in the same cycle as the result handoff.
- Latency, counted from the accept edge to the first cycle out_valid=1:
  - ceil(shamt/STEP)+1 cycles when shamt>0.
  - 1 cycle when shamt==0.
- Fill rules:
  - SRL: vacated MSBs filled with 0.
  - SRA: vacated MSBs filled with the latched in_data[WIDTH-1], held constant for the whole operation.
  - ROTR: bits shifted out of the LSB re-enter at the MSB.
- Output stability: out_data is stable while out_valid=1 and out_ready=0 (hold indefinitely). Outside DONE, out_data holds its last value.
- Input timing: in_data, in_shamt and in_op are sampled only at the accept edge. Later changes have no effect on an operation in flight.
- Reset mid-operation (SHIFT or DONE): immediate return to the reset values; the pending result is discarded and no out_valid pulse occurs.
- in_op=11: executes as SRL, no error flag.
- Arithmetic: no intermediate wider than WIDTH.

Optional Feature:
- Macro: SHIFT_RIGHT_ROTATE_EN.
- Defined: in_op=10 performs rotate right (MIPS32r2 ROTR).
- Undefined: the rotate datapath is not compiled; in_op=10 executes as SRL.

Decomposition:
- Shared package mips_shift_pkg holds:
  - typedef shift_op_t (SRL, SRA, ROTR, RSVD encodings);
  - typedef state enum (IDLE, SHIFT, DONE);
  - constants DATA_W=32 and SHAMT_W=5.
- One sub-module: shift_right_step. It is combinational; inputs are value, k (0..STEP), op and fill bit; output is the value shifted by k. It is instantiated once in the top.
- The FSM, counter and handshake stay in shift_right_unit.

Test Plan:
- SRL, STEP=1, in_data=0x80000000, shamt=4, out_ready=1 → out_data=0x08000000; out_valid first high 5 cycles after accept; in_ready=0 throughout.
- SRA, STEP=1, in_data=0xFFFFFFF0 (-16), shamt=2 → out_data=0xFFFFFFFC (-4). Also SRA 0x7FFFFFFF, shamt=31 → 0x00000000.
- shamt=0, SRA, in_data=0x12345678 → out_data=0x12345678, out_valid 1 cycle after accept. Also STEP=4, SRL 0xFFFFFFFF, shamt=31 → 0x00000001 with out_valid after 9 cycles.
- Backpressure: out_ready=0 for 6 cycles in DONE → out_valid and out_data held constant and in_ready=0; out_ready=1 → IDLE next cycle and in_ready=1.
- Reset asserted asynchronously in SHIFT (shamt=20, after 5 shift cycles) → out_valid=0, in_ready=1 immediately; a new SRL 0x00000100, shamt=8 then yields 0x00000001.
- With SHIFT_RIGHT_ROTATE_EN: ROTR 0x00000001, shamt=1 → 0x80000000. Without the macro, the same request → 0x00000000.
